// File: rtl/vpu_seq_ctrl.sv
// Command sequencer for the P-lane VPU: streams chunk reads from the vector buffer,
// aligns VPU controls with the returning data and issues result writes one stage later.
module vpu_seq_ctrl #(
    parameter int P      = 64,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic                         cmd_inv,
    input  logic [1:0]                   cmd_fp_dst,
    input  logic [1:0]                   cmd_fp_in0,
    input  logic [1:0]                   cmd_fp_in1,
    input  logic [1:0]                   cmd_th,
    input  logic [LEN_W-1:0]             cmd_len,
    input  logic [ADDR_W-1:0]            cmd_src_x,
    input  logic [ADDR_W-1:0]            cmd_src_y,
    input  logic [ADDR_W-1:0]            cmd_src_z,
    input  logic [ADDR_W-1:0]            cmd_dst,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr_x,
    output logic [ADDR_W-1:0]            rd_addr_y,
    output logic [ADDR_W-1:0]            rd_addr_z,
    output logic                         vpu_first,
    output logic                         vpu_mode,
    output logic                         vpu_acc,
    output logic                         vpu_inv,
    output logic [1:0]                   vpu_fp_dst,
    output logic [1:0]                   vpu_fp_in0,
    output logic [1:0]                   vpu_fp_in1,
    output logic [1:0]                   vpu_th,
    input  logic [P-1:0]                 vpu_nonz,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [LEN_W+$clog2(P):0]     nz_count
);

    localparam int PC_W = $clog2(P) + 1;
    localparam int NZ_W = LEN_W + $clog2(P) + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULADD = 2'b01;
    localparam logic [1:0] OP_MAC    = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [P-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int k = 0; k < P; k++) begin
            c = c + PC_W'(v[k]);
        end
        return c;
    endfunction

    function automatic logic [NZ_W-1:0] sat_add(input logic [NZ_W-1:0] a, input logic [PC_W-1:0] b);
        logic [NZ_W:0] s;
        s = {1'b0, a} + (NZ_W + 1)'(b);
        return s[NZ_W] ? {NZ_W{1'b1}} : s[NZ_W-1:0];
    endfunction

    state_t              state_q;
    logic                cmd_ready_q, busy_q, done_q, err_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_x_q, rd_addr_y_q, rd_addr_z_q;
    logic [LEN_W-1:0]    i_q;
    logic                d_q;

    logic [1:0]          op_q;
    logic                inv_q;
    logic [1:0]          fp_dst_q, fp_in0_q, fp_in1_q, th_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   src_x_q, src_y_q, src_z_q, dst_q;

    logic                s1_vld_q, s1_last_q;
    logic [LEN_W-1:0]    s1_idx_q;
    logic                vpu_first_q, vpu_mode_q, vpu_acc_q, vpu_inv_q;
    logic [1:0]          vpu_fp_dst_q, vpu_fp_in0_q, vpu_fp_in1_q, vpu_th_q;

    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [NZ_W-1:0]     nz_q, nz_d;

    logic                accept;
    logic                last_rd;
    logic [LEN_W-1:0]    nxt_i;

    assign accept  = cmd_valid && cmd_ready_q;
    assign last_rd = (i_q == len_q - LEN_W'(1));
    assign nxt_i   = i_q + LEN_W'(1);

    // Command FSM and read issue (registered outputs)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_x_q <= '0;
            rd_addr_y_q <= '0;
            rd_addr_z_q <= '0;
            i_q         <= '0;
            d_q         <= 1'b0;
            op_q        <= OP_MUL;
            inv_q       <= 1'b0;
            fp_dst_q    <= '0;
            fp_in0_q    <= '0;
            fp_in1_q    <= '0;
            th_q        <= '0;
            len_q       <= '0;
            src_x_q     <= '0;
            src_y_q     <= '0;
            src_z_q     <= '0;
            dst_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= cmd_op;
                        inv_q       <= cmd_inv;
                        fp_dst_q    <= cmd_fp_dst;
                        fp_in0_q    <= cmd_fp_in0;
                        fp_in1_q    <= cmd_fp_in1;
                        th_q        <= cmd_th;
                        len_q       <= cmd_len;
                        src_x_q     <= cmd_src_x;
                        src_y_q     <= cmd_src_y;
                        src_z_q     <= cmd_src_z;
                        dst_q       <= cmd_dst;
                        i_q         <= '0;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == '0 || cmd_op == OP_ILL) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= (cmd_op == OP_ILL);
                        end else begin
                            state_q     <= S_ISSUE;
                            rd_en_q     <= 1'b1;
                            rd_addr_x_q <= cmd_src_x;
                            rd_addr_y_q <= cmd_src_y;
                            rd_addr_z_q <= cmd_src_z;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last_rd) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                        d_q     <= 1'b0;
                    end else begin
                        i_q         <= nxt_i;
                        rd_addr_x_q <= src_x_q + ADDR_W'(nxt_i);
                        rd_addr_y_q <= src_y_q + ADDR_W'(nxt_i);
                        rd_addr_z_q <= src_z_q + ADDR_W'(nxt_i);
                    end
                end
                S_DRAIN: begin
                    if (d_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        d_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1: controls aligned with buffer data; idle cycles force all zero to clear the accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_idx_q     <= '0;
            vpu_first_q  <= 1'b0;
            vpu_mode_q   <= 1'b0;
            vpu_acc_q    <= 1'b0;
            vpu_inv_q    <= 1'b0;
            vpu_fp_dst_q <= '0;
            vpu_fp_in0_q <= '0;
            vpu_fp_in1_q <= '0;
            vpu_th_q     <= '0;
        end else if (rd_en_q) begin
            s1_vld_q     <= 1'b1;
            s1_last_q    <= last_rd;
            s1_idx_q     <= i_q;
            vpu_first_q  <= (op_q == OP_MAC) && (i_q == '0);
            vpu_mode_q   <= (op_q == OP_MAC);
            vpu_acc_q    <= (op_q == OP_MULADD);
            vpu_inv_q    <= inv_q;
            vpu_fp_dst_q <= fp_dst_q;
            vpu_fp_in0_q <= fp_in0_q;
            vpu_fp_in1_q <= fp_in1_q;
            vpu_th_q     <= th_q;
        end else begin
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_idx_q     <= '0;
            vpu_first_q  <= 1'b0;
            vpu_mode_q   <= 1'b0;
            vpu_acc_q    <= 1'b0;
            vpu_inv_q    <= 1'b0;
            vpu_fp_dst_q <= '0;
            vpu_fp_in0_q <= '0;
            vpu_fp_in1_q <= '0;
            vpu_th_q     <= '0;
        end
    end

    // Stage 2: result write; a MAC only writes its final accumulated chunk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_en_q <= s1_vld_q && ((op_q != OP_MAC) || s1_last_q);
            if (s1_vld_q) begin
                wr_addr_q <= (op_q == OP_MAC) ? dst_q : dst_q + ADDR_W'(s1_idx_q);
            end
        end
    end

    always_comb begin
        nz_d = nz_q;
        if (accept) begin
            nz_d = '0;
        end else if (wr_en_q) begin
            nz_d = sat_add(nz_q, popcount(vpu_nonz));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nz_q <= '0;
        end else begin
            nz_q <= nz_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rd_en      = rd_en_q;
    assign rd_addr_x  = rd_addr_x_q;
    assign rd_addr_y  = rd_addr_y_q;
    assign rd_addr_z  = rd_addr_z_q;
    assign vpu_first  = vpu_first_q;
    assign vpu_mode   = vpu_mode_q;
    assign vpu_acc    = vpu_acc_q;
    assign vpu_inv    = vpu_inv_q;
    assign vpu_fp_dst = vpu_fp_dst_q;
    assign vpu_fp_in0 = vpu_fp_in0_q;
    assign vpu_fp_in1 = vpu_fp_in1_q;
    assign vpu_th     = vpu_th_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign nz_count   = nz_q;

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Directed bench for vpu_seq_ctrl: cycle-accurate checks relative to each accept edge.
module tb_vpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic        cmd_inv;
    logic [1:0]  cmd_fp_dst, cmd_fp_in0, cmd_fp_in1, cmd_th;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_src_x, cmd_src_y, cmd_src_z, cmd_dst;
    logic        rd_en;
    logic [7:0]  rd_addr_x, rd_addr_y, rd_addr_z;
    logic        vpu_first, vpu_mode, vpu_acc, vpu_inv;
    logic [1:0]  vpu_fp_dst, vpu_fp_in0, vpu_fp_in1, vpu_th;
    logic [63:0] vpu_nonz;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic        busy, done, err;
    logic [14:0] nz_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vpu_seq_ctrl #(.P(64), .ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_inv(cmd_inv),
        .cmd_fp_dst(cmd_fp_dst), .cmd_fp_in0(cmd_fp_in0), .cmd_fp_in1(cmd_fp_in1), .cmd_th(cmd_th),
        .cmd_len(cmd_len), .cmd_src_x(cmd_src_x), .cmd_src_y(cmd_src_y), .cmd_src_z(cmd_src_z),
        .cmd_dst(cmd_dst),
        .rd_en(rd_en), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .rd_addr_z(rd_addr_z),
        .vpu_first(vpu_first), .vpu_mode(vpu_mode), .vpu_acc(vpu_acc), .vpu_inv(vpu_inv),
        .vpu_fp_dst(vpu_fp_dst), .vpu_fp_in0(vpu_fp_in0), .vpu_fp_in1(vpu_fp_in1), .vpu_th(vpu_th),
        .vpu_nonz(vpu_nonz), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done), .err(err), .nz_count(nz_count)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        for (int n = 0; n < 64 && cmd_ready !== 1'b1; n++) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wait_ready got %b exp 1", cmd_ready); end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] len, input logic [7:0] sx,
                        input logic [7:0] sy, input logic [7:0] sz, input logic [7:0] dst);
        cmd_op = op; cmd_len = len; cmd_src_x = sx; cmd_src_y = sy; cmd_src_z = sz; cmd_dst = dst;
        cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got %b exp 1", cmd_ready); end
        checks++; if ({busy, done, err, rd_en, wr_en} !== 5'b0) begin errors++; $display("FAIL reset ctrl got %b exp 00000", {busy, done, err, rd_en, wr_en}); end
        checks++; if ({vpu_first, vpu_mode, vpu_acc, vpu_inv} !== 4'b0) begin errors++; $display("FAIL reset vpu got %b exp 0000", {vpu_first, vpu_mode, vpu_acc, vpu_inv}); end
        checks++; if (nz_count !== 15'd0) begin errors++; $display("FAIL reset nz_count got %0d exp 0", nz_count); end
        checks++; if ({rd_addr_x, wr_addr} !== 16'h0) begin errors++; $display("FAIL reset addr got %h exp 0000", {rd_addr_x, wr_addr}); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_reset ready/busy got %b%b exp 10", cmd_ready, busy); end
    endtask

    task automatic test_mul();
        logic [7:0] ea;
        wait_ready();
        cmd_inv = 1'b1; cmd_fp_dst = 2'd2; cmd_th = 2'd1;
        send(2'b00, 8'd4, 8'h10, 8'h00, 8'h00, 8'h80);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (rd_en !== (k <= 4)) begin errors++; $display("FAIL mul rd_en k=%0d got %b", k, rd_en); end
            if (k <= 4) begin
                ea = 8'h10 + 8'(k - 1);
                checks++; if (rd_addr_x !== ea) begin errors++; $display("FAIL mul rd_addr_x k=%0d got %h exp %h", k, rd_addr_x, ea); end
            end
            checks++; if (wr_en !== (k >= 3 && k <= 6)) begin errors++; $display("FAIL mul wr_en k=%0d got %b", k, wr_en); end
            if (k >= 3 && k <= 6) begin
                ea = 8'h80 + 8'(k - 3);
                checks++; if (wr_addr !== ea) begin errors++; $display("FAIL mul wr_addr k=%0d got %h exp %h", k, wr_addr, ea); end
            end
            checks++; if (vpu_mode !== 1'b0 || vpu_first !== 1'b0) begin errors++; $display("FAIL mul mode/first k=%0d got %b%b exp 00", k, vpu_mode, vpu_first); end
            checks++; if (vpu_inv !== (k >= 2 && k <= 5)) begin errors++; $display("FAIL mul vpu_inv k=%0d got %b", k, vpu_inv); end
            if (k == 2) begin
                checks++; if (vpu_fp_dst !== 2'd2 || vpu_th !== 2'd1) begin errors++; $display("FAIL mul fields got %0d/%0d exp 2/1", vpu_fp_dst, vpu_th); end
            end
            if (k == 6) begin
                checks++; if (vpu_fp_dst !== 2'd0 || vpu_th !== 2'd0) begin errors++; $display("FAIL mul fields_idle got %0d/%0d exp 0/0", vpu_fp_dst, vpu_th); end
            end
            checks++; if (done !== (k == 7)) begin errors++; $display("FAIL mul done k=%0d got %b", k, done); end
            if (k == 7) begin
                checks++; if (nz_count !== 15'd12) begin errors++; $display("FAIL mul nz_count got %0d exp 12", nz_count); end
            end
            vpu_nonz = (k >= 3 && k <= 6) ? 64'h7 : 64'hFFFF;
        end
        vpu_nonz = '0; cmd_inv = 1'b0; cmd_fp_dst = 2'd0; cmd_th = 2'd0;
    endtask

    task automatic test_mac();
        wait_ready();
        send(2'b10, 8'd3, 8'h20, 8'h00, 8'h00, 8'h40);
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (vpu_mode !== (k >= 2 && k <= 4)) begin errors++; $display("FAIL mac vpu_mode k=%0d got %b", k, vpu_mode); end
            checks++; if (vpu_first !== (k == 2)) begin errors++; $display("FAIL mac vpu_first k=%0d got %b", k, vpu_first); end
            checks++; if (vpu_acc !== 1'b0) begin errors++; $display("FAIL mac vpu_acc k=%0d got %b exp 0", k, vpu_acc); end
            checks++; if (wr_en !== (k == 5)) begin errors++; $display("FAIL mac wr_en k=%0d got %b", k, wr_en); end
            if (k == 5) begin
                checks++; if (wr_addr !== 8'h40) begin errors++; $display("FAIL mac wr_addr got %h exp 40", wr_addr); end
            end
            checks++; if (done !== (k == 6)) begin errors++; $display("FAIL mac done k=%0d got %b", k, done); end
            if (k == 6) begin
                checks++; if (nz_count !== 15'd1) begin errors++; $display("FAIL mac nz_count got %0d exp 1", nz_count); end
            end
            vpu_nonz = 64'h8000_0000_0000_0000;
        end
        vpu_nonz = '0;
    endtask

    task automatic test_muladd();
        wait_ready();
        send(2'b01, 8'd2, 8'h00, 8'h00, 8'h00, 8'h10);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (vpu_acc !== (k == 2 || k == 3)) begin errors++; $display("FAIL muladd vpu_acc k=%0d got %b", k, vpu_acc); end
            checks++; if (vpu_mode !== 1'b0) begin errors++; $display("FAIL muladd vpu_mode k=%0d got %b exp 0", k, vpu_mode); end
            checks++; if (wr_en !== (k == 3 || k == 4)) begin errors++; $display("FAIL muladd wr_en k=%0d got %b", k, wr_en); end
            checks++; if (done !== (k == 5)) begin errors++; $display("FAIL muladd done k=%0d got %b", k, done); end
            if (k == 5) begin
                checks++; if (nz_count !== 15'd69) begin errors++; $display("FAIL muladd nz_count got %0d exp 69", nz_count); end
            end
            if (k == 6) begin
                checks++; if (nz_count !== 15'd69) begin errors++; $display("FAIL muladd nz_hold got %0d exp 69", nz_count); end
            end
            vpu_nonz = (k == 3) ? 64'h1F : (k == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hF0;
        end
        vpu_nonz = '0;
    endtask

    task automatic test_len0();
        wait_ready();
        send(2'b00, 8'd0, 8'h11, 8'h22, 8'h33, 8'h44);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL len0 rd/wr k=%0d got %b%b exp 00", k, rd_en, wr_en); end
            checks++; if (done !== (k == 1) || err !== 1'b0) begin errors++; $display("FAIL len0 done/err k=%0d got %b%b", k, done, err); end
            if (k == 2) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL len0 cmd_ready got %b exp 1", cmd_ready); end
            end
        end
    endtask

    task automatic test_illegal();
        wait_ready();
        send(2'b11, 8'd5, 8'h11, 8'h22, 8'h33, 8'h44);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL illegal rd/wr k=%0d got %b%b exp 00", k, rd_en, wr_en); end
            checks++; if (done !== (k == 1) || err !== (k == 1)) begin errors++; $display("FAIL illegal done/err k=%0d got %b%b", k, done, err); end
        end
    endtask

    task automatic test_back_to_back();
        wait_ready();
        send(2'b10, 8'd2, 8'h30, 8'h00, 8'h00, 8'h60);
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 7) begin
                checks++; if (cmd_ready !== (k == 6)) begin errors++; $display("FAIL b2b cmd_ready k=%0d got %b", k, cmd_ready); end
            end
            checks++; if (vpu_mode !== (k == 2 || k == 3 || k == 8)) begin errors++; $display("FAIL b2b vpu_mode k=%0d got %b", k, vpu_mode); end
            checks++; if (done !== (k == 5 || k == 10)) begin errors++; $display("FAIL b2b done k=%0d got %b", k, done); end
            checks++; if (wr_en !== (k == 4 || k == 9)) begin errors++; $display("FAIL b2b wr_en k=%0d got %b", k, wr_en); end
            if (k == 4) begin
                checks++; if (wr_addr !== 8'h60) begin errors++; $display("FAIL b2b wr_addr1 got %h exp 60", wr_addr); end
            end
            if (k == 9) begin
                checks++; if (wr_addr !== 8'h55) begin errors++; $display("FAIL b2b wr_addr2 got %h exp 55", wr_addr); end
            end
            if (k == 7) begin
                checks++; if (rd_en !== 1'b1 || rd_addr_x !== 8'h70) begin errors++; $display("FAIL b2b second_read got %b/%h exp 1/70", rd_en, rd_addr_x); end
            end
            if (k == 11) begin
                checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b final_ready got %b exp 1", cmd_ready); end
            end
            if (k == 1) send(2'b10, 8'd1, 8'h70, 8'h00, 8'h00, 8'h55);
            if (k == 7) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        send(2'b10, 8'd8, 8'h00, 8'h00, 8'h00, 8'h90);
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (k >= 2 && k <= 4) begin
                checks++; if (vpu_mode !== 1'b1) begin errors++; $display("FAIL rstmid pre_mode k=%0d got %b exp 1", k, vpu_mode); end
            end
            if (k == 4) begin
                rst = 1'b0;
                #1;
                checks++; if (vpu_mode !== 1'b0 || rd_en !== 1'b0) begin errors++; $display("FAIL rstmid immediate mode/rd got %b%b exp 00", vpu_mode, rd_en); end
            end
            if (k == 6) rst = 1'b1;
            if (k >= 5) begin
                checks++; if (wr_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid wr/done k=%0d got %b%b exp 00", k, wr_en, done); end
                checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || vpu_mode !== 1'b0) begin errors++; $display("FAIL rstmid idle k=%0d got %b%b%b exp 100", k, cmd_ready, busy, vpu_mode); end
            end
        end
        wait_ready();
        send(2'b00, 8'd1, 8'h05, 8'h00, 8'h00, 8'h06);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            checks++; if (rd_en !== (k == 1)) begin errors++; $display("FAIL fresh rd_en k=%0d got %b", k, rd_en); end
            if (k == 1) begin
                checks++; if (rd_addr_x !== 8'h05) begin errors++; $display("FAIL fresh rd_addr_x got %h exp 05", rd_addr_x); end
            end
            checks++; if (wr_en !== (k == 3)) begin errors++; $display("FAIL fresh wr_en k=%0d got %b", k, wr_en); end
            if (k == 3) begin
                checks++; if (wr_addr !== 8'h06) begin errors++; $display("FAIL fresh wr_addr got %h exp 06", wr_addr); end
            end
            checks++; if (done !== (k == 4)) begin errors++; $display("FAIL fresh done k=%0d got %b", k, done); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] ey, ez, ew;
        wait_ready();
        send(2'b00, 8'd3, 8'h00, 8'hFE, 8'h01, 8'hFF);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (k <= 3) begin
                ey = 8'hFE + 8'(k - 1);
                ez = 8'h01 + 8'(k - 1);
                checks++; if (rd_addr_y !== ey || rd_addr_z !== ez) begin errors++; $display("FAIL wrap rd_addr_yz k=%0d got %h/%h exp %h/%h", k, rd_addr_y, rd_addr_z, ey, ez); end
            end
            if (k >= 3 && k <= 5) begin
                ew = 8'hFF + 8'(k - 3);
                checks++; if (wr_en !== 1'b1 || wr_addr !== ew) begin errors++; $display("FAIL wrap wr k=%0d got %b/%h exp 1/%h", k, wr_en, wr_addr, ew); end
            end
            checks++; if (done !== (k == 6)) begin errors++; $display("FAIL wrap done k=%0d got %b", k, done); end
        end
    endtask

    task automatic test_long();
        int rd_cnt = 0, wr_cnt = 0, done_at = -1;
        wait_ready();
        send(2'b00, 8'd255, 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        for (int k = 1; k <= 262; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (rd_en === 1'b1) rd_cnt++;
            if (wr_en === 1'b1) wr_cnt++;
            if (done === 1'b1 && done_at < 0) done_at = k;
            if (k == 255) begin
                checks++; if (rd_addr_x !== 8'hFE) begin errors++; $display("FAIL long last_addr got %h exp fe", rd_addr_x); end
            end
            if (k == 258) begin
                checks++; if (nz_count !== 15'd255) begin errors++; $display("FAIL long nz_count got %0d exp 255", nz_count); end
            end
            vpu_nonz = 64'h0100;
        end
        vpu_nonz = '0;
        checks++; if (rd_cnt != 255) begin errors++; $display("FAIL long rd_count got %0d exp 255", rd_cnt); end
        checks++; if (wr_cnt != 255) begin errors++; $display("FAIL long wr_count got %0d exp 255", wr_cnt); end
        checks++; if (done_at != 258) begin errors++; $display("FAIL long done_cycle got %0d exp 258", done_at); end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_inv = 1'b0;
        cmd_fp_dst = 2'd0; cmd_fp_in0 = 2'd0; cmd_fp_in1 = 2'd0; cmd_th = 2'd0;
        cmd_len = 8'd0; cmd_src_x = 8'd0; cmd_src_y = 8'd0; cmd_src_z = 8'd0; cmd_dst = 8'd0;
        vpu_nonz = '0;
        test_reset();
        test_mul();
        test_mac();
        test_muladd();
        test_len0();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vpu_seq_ctrl.md
# vpu_seq_ctrl

Command-driven sequencer for the P-lane vector processing unit. It accepts one vector command at a time and streams chunk reads from the vector buffer. It drives the VPU control fields aligned with the buffer read data, then writes results back once the VPU's single pipeline stage has passed. It sits between the top-level instruction decoder and the VPU/vector-buffer pair, and also reports per-command non-zero counts from the VPU pruning output.

## Interface
Parameters:
- P, 64, VPU lane count (width of nonz vector)
- ADDR_W, 8, vector-buffer address width
- LEN_W, 8, chunk-count width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 MUL, 01 MULADD, 10 MAC, 11 illegal
- cmd_inv, in, 1, VPU inversion flag
- cmd_fp_dst / cmd_fp_in0 / cmd_fp_in1 / cmd_th  in  2 each  format and threshold fields
- cmd_len  in  LEN_W  number of chunks
- cmd_src_x / cmd_src_y / cmd_src_z / cmd_dst  in  ADDR_W each  base addresses
- rd_en  out  1  buffer read strobe; data reaches VPU one cycle later
- rd_addr_x / rd_addr_y / rd_addr_z  out  ADDR_W each  read addresses
- vpu_first / vpu_mode / vpu_acc / vpu_inv  out  1 each  VPU controls
- vpu_fp_dst / vpu_fp_in0 / vpu_fp_in1 / vpu_th  out  2 each  VPU controls
- vpu_nonz  in  P  VPU non-zero flags, valid in the write cycle
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  result write address
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  pulses with done for an illegal op
- nz_count  out  LEN_W+$clog2(P)+1  non-zero total of written results

## Operation
- FSM states: IDLE, ISSUE, DRAIN (2 cycles, counter d), DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd fields, clear chunk counter i and nz_count.
  - len=0 or op=11: go to DONE.
  - Otherwise go to ISSUE.
- ISSUE: rd_en=1; rd_addr_* = base_* + i (mod 2^ADDR_W wrap). On i==len-1 go to DRAIN, else i++.
- DRAIN: no reads. After 2 cycles go to DONE.
- DONE: done=1; err=1 if op=11. Next state is IDLE.
- Stage-1 register, aligned with buffer data at the VPU inputs (one cycle after rd_en):
  - vpu_mode = (op==MAC); vpu_acc = (op==MULADD); vpu_first = (op==MAC && i==0); inv, fp, and th fields from the latched command.
  - When no valid chunk is present, vpu_mode=0 and all other controls are 0 (this clears the VPU accumulator).
- Stage-2 register (one cycle later) produces the write:
  - MUL/MULADD: wr_en for every chunk, wr_addr = dst + i.
  - MAC: wr_en only for chunk len-1, wr_addr = dst.
- On every wr_en cycle, nz_count += popcount(vpu_nonz). It saturates at its max value.
- vpu_mode is held at 1 across all chunks of a MAC so the VPU accumulator is never reset mid-command.

## Timing
- Reset values: state IDLE, cmd_ready=1, all other outputs 0, nz_count=0.
- Let A be the handshake edge, with len=L≥1:
  - chunk i is read in cycle A+1+i;
  - VPU controls for chunk i are present in cycle A+2+i;
  - the write for chunk i occurs in cycle A+3+i;
  - DRAIN occupies A+L+1 and A+L+2;
  - done fires in A+L+3;
  - cmd_ready returns in A+L+4.
- len=0 or op=11: done (and err) fires in A+1, with no rd_en or wr_en.
- nz_count is final and stable in the done cycle and holds until the next accept.
- cmd_valid held high continuously: the next accept happens on the first IDLE cycle, with no bubble beyond the fixed DONE cycle.
- Reset asserted mid-command: immediate return to IDLE. Any in-flight write is squashed (wr_en=0), vpu_mode=0, and done does not pulse.
- L = 2^LEN_W−1 must complete without counter overflow. Address wrap is modulo 2^ADDR_W.

## Test plan
- MUL, L=4, src_x=0x10, dst=0x80, accept at A → rd_addr_x 0x10..0x13 in A+1..A+4; wr_addr 0x80..0x83 in A+3..A+6; vpu_mode=0 and vpu_first=0 throughout; done at A+7.
- MAC, L=3, dst=0x40 → vpu_mode=1 in A+2..A+4; vpu_first=1 only in A+2; exactly one wr_en, in A+5, with wr_addr 0x40; vpu_mode=0 in A+5.
- MULADD, L=2, with vpu_nonz popcounts 5 and 64 on the two writes → vpu_acc=1 in A+2..A+3; nz_count=69 at done.
- Separately, L=0 → done in A+1 with no reads or writes. op=11, L=5 → done and err together in A+1 with no reads.
- Two commands back-to-back with cmd_valid held high, first has L=2 → second accept lands in cycle A+6; the MAC accumulator sees vpu_mode=0 for at least one cycle between the commands.
- MAC with L=8, rst driven low in A+4 and released two cycles later → no wr_en and no done; state IDLE with cmd_ready=1; a fresh command then completes normally.
